// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - upstream, alu and writeback signals of the execute stage
// The out_zero/out_negative flags exist only when ALU_EXEC_FLAGS_EN is defined.
interface alu_exec_stage_if #(parameter int TAG_WIDTH = 5);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_operation;
  logic [31:0]          in_operand0;
  logic [31:0]          in_operand1;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [3:0]           alu_operation;
  logic [31:0]          alu_operand0;
  logic [31:0]          alu_operand1;
  logic [31:0]          alu_dest;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_result;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_illegal;
  logic                 busy;
`ifdef ALU_EXEC_FLAGS_EN
  logic                 out_zero;
  logic                 out_negative;

  modport slave (
    input  in_valid, in_operation, in_operand0, in_operand1, in_tag, alu_dest, out_ready,
    output in_ready, alu_operation, alu_operand0, alu_operand1,
    output out_valid, out_result, out_tag, out_illegal, busy, out_zero, out_negative
  );
  modport master (
    output in_valid, in_operation, in_operand0, in_operand1, in_tag, alu_dest, out_ready,
    input  in_ready, alu_operation, alu_operand0, alu_operand1,
    input  out_valid, out_result, out_tag, out_illegal, busy, out_zero, out_negative
  );
`else
  modport slave (
    input  in_valid, in_operation, in_operand0, in_operand1, in_tag, alu_dest, out_ready,
    output in_ready, alu_operation, alu_operand0, alu_operand1,
    output out_valid, out_result, out_tag, out_illegal, busy
  );
  modport master (
    output in_valid, in_operation, in_operand0, in_operand1, in_tag, alu_dest, out_ready,
    input  in_ready, alu_operation, alu_operand0, alu_operand1,
    input  out_valid, out_result, out_tag, out_illegal, busy
  );
`endif
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered execute stage wrapping a combinational alu
// Optional result flags (out_zero/out_negative) enabled by defining ALU_EXEC_FLAGS_EN.
module alu_exec_stage #(
  parameter int TAG_WIDTH  = 5,
  parameter int MUL_CYCLES = 2
) (
  input logic              clock,
  input logic              reset,
  alu_exec_stage_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [31:0]          a_q, a_d, b_q, b_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, otag_q, otag_d;
  logic [31:0]          res_q, res_d;
  logic                 ill_q, ill_d;
  logic                 in_ready, accept, legal;
`ifdef ALU_EXEC_FLAGS_EN
  logic                 zero_q, zero_d, neg_q, neg_d;
`endif

  assign legal    = op_q inside {OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_NOT, OP_XOR, OP_AND};
  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    otag_d  = otag_q;
    res_d   = res_q;
    ill_d   = ill_q;
`ifdef ALU_EXEC_FLAGS_EN
    zero_d  = zero_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      EXEC: begin
        if (op_q == OP_MUL && cnt_q != MUL_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          res_d   = legal ? bus.alu_dest : 32'd0;
          ill_d   = !legal;
          otag_d  = tag_q;
`ifdef ALU_EXEC_FLAGS_EN
          zero_d  = legal && (bus.alu_dest == 32'd0);
          neg_d   = legal && bus.alu_dest[31];
`endif
          state_d = DONE;
        end
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: ;
    endcase
    // An accept in DONE overrides the drain to IDLE: back-to-back issue.
    if (accept) begin
      op_d    = bus.in_operation;
      a_d     = bus.in_operand0;
      b_d     = bus.in_operand1;
      tag_d   = bus.in_tag;
      cnt_d   = 4'd0;
      state_d = EXEC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      tag_q   <= '0;
      otag_q  <= '0;
      res_q   <= 32'd0;
      ill_q   <= 1'b0;
`ifdef ALU_EXEC_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      otag_q  <= otag_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
`ifdef ALU_EXEC_FLAGS_EN
      zero_q  <= zero_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.alu_operation = op_q;
  assign bus.alu_operand0  = a_q;
  assign bus.alu_operand1  = b_q;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_result    = res_q;
  assign bus.out_tag       = otag_q;
  assign bus.out_illegal   = ill_q;
  assign bus.busy          = (state_q != IDLE);
`ifdef ALU_EXEC_FLAGS_EN
  assign bus.out_zero      = zero_q;
  assign bus.out_negative  = neg_q;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4, OP_XOR = 4'h5, OP_AND = 4'h6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  logic seen;

  alu_exec_stage_if #(.TAG_WIDTH(5)) bus ();
  alu_exec_stage #(.TAG_WIDTH(5), .MUL_CYCLES(2)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Reference combinational alu; illegal codes return junk so the stage must zero it.
  always_comb begin
    case (bus.alu_operation)
      OP_ADD:  bus.alu_dest = bus.alu_operand0 + bus.alu_operand1;
      OP_SUB:  bus.alu_dest = bus.alu_operand0 - bus.alu_operand1;
      OP_MUL:  bus.alu_dest = bus.alu_operand0 * bus.alu_operand1;
      OP_OR:   bus.alu_dest = bus.alu_operand0 | bus.alu_operand1;
      OP_NOT:  bus.alu_dest = ~bus.alu_operand0;
      OP_XOR:  bus.alu_dest = bus.alu_operand0 ^ bus.alu_operand1;
      OP_AND:  bus.alu_dest = bus.alu_operand0 & bus.alu_operand1;
      default: bus.alu_dest = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int lt);
    int w;
    bus.in_valid = 1'b1; bus.in_operation = op;
    bus.in_operand0 = a; bus.in_operand1 = b; bus.in_tag = tag;
    w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clock); #1; w++; end
    if (w >= 20) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lt = 1;
    while (!bus.out_valid && lt < 40) begin @(posedge clock); #1; lt++; end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_operation = 4'h0; bus.in_operand0 = 32'd0;
    bus.in_operand1 = 32'd0; bus.in_tag = 5'd0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_operand0", bus.alu_operand0, 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);

    run_op(OP_ADD, 32'hFFFFFFFF, 32'h00000002, 5'd3, lat);
    chk("add_lat", lat, 2);
    chk("add_res", bus.out_result, 32'h00000001);
    chk("add_tag", 32'(bus.out_tag), 32'd3);
    chk("add_ill", 32'(bus.out_illegal), 32'd0);
    chk("add_busy", 32'(bus.busy), 32'd1);
`ifdef ALU_EXEC_FLAGS_EN
    chk("add_zero", 32'(bus.out_zero), 32'd0);
    chk("add_neg", 32'(bus.out_negative), 32'd0);
`endif
    drain();

    run_op(OP_MUL, 32'h00010000, 32'h00010000, 5'd4, lat);
    chk("mul_lat", lat, 3);
    chk("mul_res", bus.out_result, 32'h00000000);
`ifdef ALU_EXEC_FLAGS_EN
    chk("mul_zero", 32'(bus.out_zero), 32'd1);
`endif
    drain();

    run_op(OP_SUB, 32'd5, 32'd7, 5'd7, lat);
    chk("sub_lat", lat, 2);
    chk("sub_res", bus.out_result, 32'hFFFFFFFE);
    chk("sub_tag", 32'(bus.out_tag), 32'd7);
`ifdef ALU_EXEC_FLAGS_EN
    chk("sub_neg", 32'(bus.out_negative), 32'd1);
`endif
    drain();

    run_op(OP_ADD, 32'd10, 32'd20, 5'd9, lat);
    bus.in_valid = 1'b1; bus.in_operation = OP_OR;
    bus.in_operand0 = 32'h000000F0; bus.in_operand1 = 32'h0000000F; bus.in_tag = 5'd12;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_res", bus.out_result, 32'd30);
      chk("bp_tag", 32'(bus.out_tag), 32'd9);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    chk("b2b_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("b2b_op", 32'(bus.alu_operation), 32'(OP_OR));
    @(posedge clock); #1;
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_res", bus.out_result, 32'h000000FF);
    chk("b2b_tag", 32'(bus.out_tag), 32'd12);
    drain();

    run_op(4'hF, 32'd1, 32'd2, 5'd1, lat);
    chk("ill_res", bus.out_result, 32'd0);
    chk("ill_flag", 32'(bus.out_illegal), 32'd1);
`ifdef ALU_EXEC_FLAGS_EN
    chk("ill_zero", 32'(bus.out_zero), 32'd0);
    chk("ill_neg", 32'(bus.out_negative), 32'd0);
`endif
    drain();

    run_op(OP_XOR, 32'h0000F0F0, 32'h0000FFFF, 5'd2, lat);
    chk("xor_res", bus.out_result, 32'h00000F0F);
    chk("xor_ill", 32'(bus.out_illegal), 32'd0);
    drain();

    run_op(OP_NOT, 32'h0000FFFF, 32'h00001234, 5'd5, lat);
    chk("not_res", bus.out_result, 32'hFFFF0000);
    drain();

    run_op(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd31, lat);
    chk("and_res", bus.out_result, 32'h0F000F00);
    chk("and_tag", 32'(bus.out_tag), 32'd31);
    drain();

    bus.in_valid = 1'b1; bus.in_operation = OP_MUL;
    bus.in_operand0 = 32'd3; bus.in_operand1 = 32'd4; bus.in_tag = 5'd6;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_operand0", bus.alu_operand0, 32'd0);
    seen = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      seen = seen | bus.out_valid;
    end
    bus.out_ready = 1'b0;
    chk("mid_rst_no_result", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
